// File: rtl/instr_emitter_pkg.sv
// Shared opcodes, op-class constants and state encoding for the instruction emitter.
package instr_emitter_pkg;

    localparam logic [2:0] OPC_OP0  = 3'b000;
    localparam logic [2:0] OPC_OP1  = 3'b001;
    localparam logic [2:0] OPC_OP2  = 3'b010;
    localparam logic [2:0] OPC_OP3  = 3'b011;
    localparam logic [2:0] OPC_OP4  = 3'b100;
    localparam logic [2:0] OPC_MODE = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_MODE,
        EMIT_OP,
        EMIT_HALT,
        HALTED
    } emit_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OPC_OP4);
    endfunction

endpackage

// File: rtl/instr_emitter.sv
// Turns abstract op requests into decoder instruction words, inserting mode-set
// words only when the shadow of the decoder's mode register S is stale or differs.
module instr_emitter
    import instr_emitter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [1:0]       req_mode,
    input  logic [5:0]       req_operand,
    input  logic             mode_inval,
    output logic [8:0]       out_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count,
    output logic [1:0]       mode_shadow,
    output logic             shadow_valid
);

    emit_state_t      r_state, w_state_next;
    logic [8:0]       r_out_instr, w_out_instr_next;
    logic             r_out_valid, w_out_valid_next;
    logic             r_halted, w_halted_next;
    logic             r_err, w_err_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic [1:0]       r_mode_shadow, w_mode_shadow_next;
    logic             r_shadow_valid, w_shadow_valid_next;
    logic             r_inval_pend, w_inval_pend_next;
    logic [2:0]       r_op, w_op_next;
    logic [1:0]       r_mode, w_mode_next;
    logic [5:0]       r_operand, w_operand_next;

    logic             w_req_fire;
    logic             w_out_fire;
    logic             w_need_mode;

    assign req_ready    = (r_state == IDLE) && !Reset;
    assign w_req_fire   = req_valid && req_ready;
    assign w_out_fire   = r_out_valid && out_ready;
    // An invalidate arriving with the request counts as already applied.
    assign w_need_mode  = !r_shadow_valid || mode_inval || (r_mode_shadow != req_mode);

    assign out_instr    = r_out_instr;
    assign out_valid    = r_out_valid;
    assign halted       = r_halted;
    assign err          = r_err;
    assign instr_count  = r_count;
    assign mode_shadow  = r_mode_shadow;
    assign shadow_valid = r_shadow_valid;

    always_comb begin
        w_state_next        = r_state;
        w_out_instr_next    = r_out_instr;
        w_out_valid_next    = r_out_valid;
        w_halted_next       = r_halted;
        w_err_next          = r_err;
        w_count_next        = r_count;
        w_mode_shadow_next  = r_mode_shadow;
        w_shadow_valid_next = r_shadow_valid;
        w_inval_pend_next   = r_inval_pend;
        w_op_next           = r_op;
        w_mode_next         = r_mode;
        w_operand_next      = r_operand;

        if (w_out_fire && (r_count != {CNT_W{1'b1}})) begin
            w_count_next = r_count + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (mode_inval) begin
                    w_shadow_valid_next = 1'b0;
                end
                if (w_req_fire) begin
                    w_op_next      = req_op;
                    w_mode_next    = req_mode;
                    w_operand_next = req_operand;
                    if (req_op == OPC_HALT) begin
                        w_state_next     = EMIT_HALT;
                        w_out_instr_next = {OPC_HALT, 6'b0};
                        w_out_valid_next = 1'b1;
                    end else if (!is_legal_op(req_op)) begin
                        w_err_next = 1'b1;
                    end else if (w_need_mode) begin
                        w_state_next     = EMIT_MODE;
                        w_out_instr_next = {OPC_MODE, 4'b0000, req_mode};
                        w_out_valid_next = 1'b1;
                    end else begin
                        w_state_next     = EMIT_OP;
                        w_out_instr_next = {req_op, req_operand};
                        w_out_valid_next = 1'b1;
                    end
                end
            end
            EMIT_MODE: begin
                if (mode_inval) begin
                    w_inval_pend_next = 1'b1;
                end
                if (w_out_fire) begin
                    w_mode_shadow_next  = r_mode;
                    w_shadow_valid_next = 1'b1;
                    w_state_next        = EMIT_OP;
                    w_out_instr_next    = {r_op, r_operand};
                end
            end
            EMIT_OP: begin
                if (mode_inval) begin
                    w_inval_pend_next = 1'b1;
                end
                if (w_out_fire) begin
                    w_state_next      = IDLE;
                    w_out_valid_next  = 1'b0;
                    w_inval_pend_next = 1'b0;
                    // A pending invalidate wins over the shadow update made by the mode-set word.
                    if (r_inval_pend || mode_inval) begin
                        w_shadow_valid_next = 1'b0;
                    end
                end
            end
            EMIT_HALT: begin
                if (mode_inval) begin
                    w_inval_pend_next = 1'b1;
                end
                if (w_out_fire) begin
                    w_state_next      = HALTED;
                    w_out_valid_next  = 1'b0;
                    w_halted_next     = 1'b1;
                    w_inval_pend_next = 1'b0;
                end
            end
            HALTED: begin
            end
            default: begin
                w_state_next     = IDLE;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= IDLE;
            r_out_instr    <= '0;
            r_out_valid    <= 1'b0;
            r_halted       <= 1'b0;
            r_err          <= 1'b0;
            r_count        <= '0;
            r_mode_shadow  <= 2'b00;
            r_shadow_valid <= 1'b0;
            r_inval_pend   <= 1'b0;
            r_op           <= '0;
            r_mode         <= '0;
            r_operand      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_out_instr    <= w_out_instr_next;
            r_out_valid    <= w_out_valid_next;
            r_halted       <= w_halted_next;
            r_err          <= w_err_next;
            r_count        <= w_count_next;
            r_mode_shadow  <= w_mode_shadow_next;
            r_shadow_valid <= w_shadow_valid_next;
            r_inval_pend   <= w_inval_pend_next;
            r_op           <= w_op_next;
            r_mode         <= w_mode_next;
            r_operand      <= w_operand_next;
        end
    end

endmodule

// File: tb/tb_instr_emitter.sv
// Self-checking bench: directed table, random requests against a word-list model,
// and hand-written reset/halt corner sequences. Drives and samples on the falling edge.
module tb_instr_emitter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [1:0]  req_mode = '0;
    logic [5:0]  req_operand = '0;
    logic        mode_inval = 1'b0;
    logic        out_ready = 1'b0;

    logic        req_ready, out_valid, halted, err, shadow_valid;
    logic [8:0]  out_instr;
    logic [15:0] instr_count;
    logic [1:0]  mode_shadow;

    logic        req_ready2, out_valid2, halted2, err2, shadow_valid2;
    logic [8:0]  out_instr2;
    logic [1:0]  instr_count2;
    logic [1:0]  mode_shadow2;

    always #5 Clk = ~Clk;

    instr_emitter #(.CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_mode(req_mode), .req_operand(req_operand),
        .mode_inval(mode_inval), .out_instr(out_instr), .out_valid(out_valid),
        .out_ready(out_ready), .halted(halted), .err(err), .instr_count(instr_count),
        .mode_shadow(mode_shadow), .shadow_valid(shadow_valid)
    );

    // Narrow-counter copy fed the same stimulus; only its saturation is of interest.
    instr_emitter #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready2),
        .req_op(req_op), .req_mode(req_mode), .req_operand(req_operand),
        .mode_inval(mode_inval), .out_instr(out_instr2), .out_valid(out_valid2),
        .out_ready(out_ready), .halted(halted2), .err(err2), .instr_count(instr_count2),
        .mode_shadow(mode_shadow2), .shadow_valid(shadow_valid2)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [1:0] m_mode;
    bit         m_valid;
    bit         m_err;
    bit         m_halted;
    int         m_count;

    logic [8:0] obs[4];
    int         obs_n;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 2'b00; m_valid = 0; m_err = 0; m_halted = 0; m_count = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, " out_valid"},   32'(out_valid), 0);
        check({tag, " req_ready"},   32'(req_ready), 32'(!m_halted));
        check({tag, " halted"},      32'(halted), 32'(m_halted));
        check({tag, " err"},         32'(err), 32'(m_err));
        check({tag, " count"},       32'(instr_count), 32'((m_count > 65535) ? 65535 : m_count));
        check({tag, " count_sat"},   32'(instr_count2), 32'((m_count > 3) ? 3 : m_count));
        check({tag, " shadow_valid"}, 32'(shadow_valid), 32'(m_valid));
        if (m_valid) check({tag, " mode_shadow"}, 32'(mode_shadow), 32'(m_mode));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        check("ready_in_reset", 32'(req_ready), 0);
        Reset = 1'b0;
        @(negedge Clk);
        model_reset();
        check("rst out_instr", 32'(out_instr), 0);
        check("rst mode_shadow", 32'(mode_shadow), 0);
        check_state("rst");
    endtask

    // Called at a falling edge with the emitter idle.
    task automatic apply_req(input logic [2:0] op, input logic [1:0] mode, input logic [5:0] operand,
                             input bit inval_req, input int inval_word, input int stall, input int pct);
        logic [8:0] exp_w[$];
        int  idx, cyc;
        bit  inv_seen, fired;
        check("req_ready before req", 32'(req_ready), 32'(!m_halted));
        if (inval_req) m_valid = 0;
        exp_w = {};
        if (op == 3'b111) exp_w.push_back(9'h1C0);
        else if (op == 3'b101 || op == 3'b110) m_err = 1;
        else begin
            if (!m_valid || m_mode != mode) exp_w.push_back({3'b110, 4'b0000, mode});
            exp_w.push_back({op, operand});
        end
        req_valid = 1; req_op = op; req_mode = mode; req_operand = operand; mode_inval = inval_req;
        @(posedge Clk); @(negedge Clk);
        req_valid = 0; mode_inval = 0;
        obs_n = 0; idx = 0; cyc = 0; inv_seen = 0;
        while (idx < exp_w.size()) begin
            if (cyc >= 200) begin
                check("word timeout", 32'(idx), 32'(exp_w.size()));
                break;
            end
            check("out_valid held", 32'(out_valid), 1);
            check("out_instr", 32'(out_instr), 32'(exp_w[idx]));
            check("req_ready busy", 32'(req_ready), 0);
            if (obs_n < 4) obs[obs_n] = out_instr;
            out_ready  = (idx == 0 && cyc < stall) ? 1'b0 : ($urandom_range(1, 100) <= pct);
            mode_inval = (idx == inval_word);
            if (idx == inval_word) inv_seen = 1;
            fired = out_ready;
            @(posedge Clk); @(negedge Clk);
            out_ready = 0; mode_inval = 0;
            if (fired) begin
                m_count++;
                if (exp_w[idx][8:6] == 3'b110) begin m_mode = exp_w[idx][1:0]; m_valid = 1; end
                if (exp_w[idx] == 9'h1C0) m_halted = 1;
                obs_n++; idx++; cyc = 0;
            end else cyc++;
        end
        if (inv_seen && !m_halted) m_valid = 0;
        check_state("post_req");
    endtask

    typedef struct {
        logic [2:0] op; logic [1:0] mode; logic [5:0] operand;
        bit inval_req; int inval_word; int stall;
        int n; logic [8:0] w0; logic [8:0] w1; int count; logic [1:0] shadow; bit sv; bit errx;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [8:0] exp0;
        tbl[0] = '{3'd1, 2'd3, 6'h2A, 0, -1, 0, 2, 9'h183, 9'h06A, 2,  2'd3, 1, 0};
        tbl[1] = '{3'd1, 2'd3, 6'h05, 0, -1, 0, 1, 9'h045, 9'h000, 3,  2'd3, 1, 0};
        tbl[2] = '{3'd3, 2'd1, 6'h10, 0, -1, 4, 2, 9'h181, 9'h0D0, 5,  2'd1, 1, 0};
        tbl[3] = '{3'd3, 2'd1, 6'h11, 0,  0, 0, 1, 9'h0D1, 9'h000, 6,  2'd1, 0, 0};
        tbl[4] = '{3'd3, 2'd1, 6'h12, 0, -1, 0, 2, 9'h181, 9'h0D2, 8,  2'd1, 1, 0};
        tbl[5] = '{3'd6, 2'd0, 6'h00, 0, -1, 0, 0, 9'h000, 9'h000, 8,  2'd1, 1, 1};
        tbl[6] = '{3'd0, 2'd1, 6'h3F, 1, -1, 0, 2, 9'h181, 9'h03F, 10, 2'd1, 1, 1};
        tbl[7] = '{3'd4, 2'd1, 6'h00, 0, -1, 0, 1, 9'h100, 9'h000, 11, 2'd1, 1, 1};

        @(negedge Clk); @(negedge Clk);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            apply_req(tbl[i].op, tbl[i].mode, tbl[i].operand, tbl[i].inval_req,
                      tbl[i].inval_word, tbl[i].stall, 100);
            check($sformatf("tbl%0d nwords", i), 32'(obs_n), 32'(tbl[i].n));
            if (tbl[i].n > 0) check($sformatf("tbl%0d w0", i), 32'(obs[0]), 32'(tbl[i].w0));
            if (tbl[i].n > 1) check($sformatf("tbl%0d w1", i), 32'(obs[1]), 32'(tbl[i].w1));
            check($sformatf("tbl%0d count", i), 32'(instr_count), 32'(tbl[i].count));
            check($sformatf("tbl%0d shadow", i), 32'(mode_shadow), 32'(tbl[i].shadow));
            check($sformatf("tbl%0d sv", i), 32'(shadow_valid), 32'(tbl[i].sv));
            check($sformatf("tbl%0d err", i), 32'(err), 32'(tbl[i].errx));
            $display("vec %0d op=%0d mode=%0d words=%0d count=%0d", i, tbl[i].op, tbl[i].mode, obs_n, instr_count);
        end

        for (int i = 0; i < 150; i++) begin
            int r;
            logic [2:0] op;
            r = $urandom_range(0, 11);
            op = (r < 10) ? 3'($urandom_range(0, 4)) : ((r == 10) ? 3'b101 : 3'b110);
            apply_req(op, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : -1,
                      $urandom_range(0, 2), $urandom_range(30, 100));
            $display("rnd %0d op=%0d words=%0d count=%0d", i, op, obs_n, instr_count);
        end

        // Reset while a word is stalled downstream.
        exp0 = (!m_valid || m_mode != 2'b10) ? 9'h182 : 9'h09B;
        req_valid = 1; req_op = 3'd2; req_mode = 2'b10; req_operand = 6'h1B;
        @(posedge Clk); @(negedge Clk);
        req_valid = 0;
        check("midreset word", 32'(out_instr), 32'(exp0));
        check("midreset valid", 32'(out_valid), 1);
        do_reset();
        $display("midreset count=%0d", instr_count);

        apply_req(3'd2, 2'd2, 6'h01, 0, -1, 0, 100);
        apply_req(3'd7, 2'd0, 6'h00, 0, 0, 2, 100);
        check("halt word", 32'(obs[0]), 32'h1C0);
        $display("halt words=%0d halted=%0d", obs_n, halted);

        for (int c = 0; c < 4; c++) begin
            req_valid = 1; req_op = 3'd1; mode_inval = c[0]; out_ready = 1;
            @(posedge Clk); @(negedge Clk);
            check("halted ready", 32'(req_ready), 0);
            check("halted valid", 32'(out_valid), 0);
            check("halted count", 32'(instr_count), 32'(m_count));
            check("halted flag", 32'(halted), 1);
        end
        req_valid = 0; mode_inval = 0; out_ready = 0;
        $display("halted hold count=%0d", instr_count);

        do_reset();
        $display("final reset halted=%0d count=%0d", halted, instr_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_emitter.md
Name: instr_emitter

Overview:
- Encoder side of the 9-bit control-decoder instruction stream.
- Accepts abstract requests (op class, mode, 6-bit operand) and emits a legal instruction sequence for the decoder.
- Tracks a shadow copy of the decoder's latched mode register S. It inserts a mode-set word (opcode 3'b110) only when the requested mode differs from S or S is unknown.
- Sits between the program generator / test sequencer and the instruction path feeding Ctrl. Also emits the halt word (3'b111) that raises Ack.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  emitter can capture a request this cycle
- req_op  input  3  op class; 000-100 legal, 111 halt, 101/110 illegal
- req_mode  input  2  mode S the op requires
- req_operand  input  6  placed verbatim in instruction bits [5:0]
- mode_inval  input  1  decoder S no longer trusted; force the next mode-set
- out_instr  output  9  instruction word to the decoder
- out_valid  output  1  out_instr valid
- out_ready  input  1  downstream accepts out_instr this cycle
- halted  output  1  halt word has been accepted; block is frozen
- err  output  1  sticky; an illegal req_op was received
- instr_count  output  CNT_W  words accepted downstream, saturating
- mode_shadow  output  2  current shadow of S
- shadow_valid  output  1  mode_shadow matches the decoder

Behaviour:
- Reset (Clk edge with Reset=1): state=IDLE, out_instr=0, out_valid=0, halted=0, err=0, instr_count=0, mode_shadow=00, shadow_valid=0, inval_pend=0. Reset mid-operation abandons any held word with no output handshake.
- All outputs are registered. req_ready = (state==IDLE) && !Reset.
- Handshakes:
  - Request accepted on req_valid && req_ready.
  - Output word accepted on out_valid && out_ready.
  - out_instr and out_valid are held stable until accepted.
- Encodings:
  - Mode-set word = {3'b110, 4'b0000, mode}.
  - Op word = {op, operand}.
  - Halt word = {3'b111, 6'b0}.
- State IDLE, on accept (capture op/mode/operand into hold regs):
  - op==111: go to EMIT_HALT with out_instr=halt word, out_valid=1 next cycle.
  - op in {101, 110}: err<=1, request dropped, stay IDLE, no output.
  - legal op with need_mode = !shadow_valid || mode_shadow!=req_mode: go to EMIT_MODE with the mode-set word.
  - legal op otherwise: go to EMIT_OP with the op word.
- Latency: first word has out_valid=1 one cycle after request acceptance.
- EMIT_MODE, on out handshake:
  - mode_shadow<=held mode, shadow_valid<=1.
  - Next cycle presents the op word (EMIT_OP).
- EMIT_OP, on out handshake: go to IDLE, out_valid<=0.
- EMIT_HALT, on out handshake: go to HALTED, out_valid<=0, halted<=1.
- HALTED: req_ready=0, requests ignored; only Reset exits.
- mode_inval:
  - In IDLE: shadow_valid<=0. If a request is accepted in the same cycle, need_mode is evaluated as if shadow_valid=0.
  - In EMIT_MODE, EMIT_OP or EMIT_HALT: sets inval_pend. The pending invalidate clears shadow_valid on the transition back to IDLE and overrides the EMIT_MODE update in the same sequence.
  - In HALTED: ignored.
- instr_count: +1 per out handshake for all three word types; saturates at all-ones, no wrap.
- Throughput: minimum 2 cycles per op when no mode-set is needed, 3 when one is.

Decomposition:
- Shared definitions package holds:
  - OPC_MODE=3'b110 and OPC_HALT=3'b111.
  - Legal op-class constants 000-100.
  - The emitter state enum {IDLE, EMIT_MODE, EMIT_OP, EMIT_HALT, HALTED}.
- No sub-module; the saturating counter stays inline.

Test Plan:
- Reset, then request op=001 mode=11 operand=6'h2A with out_ready=1 -> words 9'h183 then 9'h06A; shadow=11 valid; instr_count=2.
- Follow with op=001 mode=11 operand=6'h05 -> single word 9'h045 (no mode-set); instr_count=3.
- Request op=011 mode=01 with out_ready=0 for 4 cycles -> out_instr=9'h181 held stable with out_valid=1 and req_ready=0 until out_ready rises, then the op word follows.
- Pulse mode_inval during EMIT_OP, then request again with the same mode -> mode-set word re-emitted before the op.
- Request op=110 -> err=1 sticky, no out_valid, state stays IDLE. Then op=111 -> 9'h1C0 emitted, halted=1, req_ready=0 thereafter; Reset clears everything.
- Force instr_count to saturation with CNT_W=2 (4+ words) -> count stays 2'b11.
